mem_access_ctrl: RTL and testbench

- Load/store sequencer that sits directly upstream of the 8-entry data memory.
- Accepts one request at a time from the datapath: load, store, or optional clear.
- Drives the memory's write-enable, address and write-data lines; captures read data into a result register.
- Returns a one-cycle done pulse per request; the memory has a combinational read path and writes on the clock edge when write-enable is high.

---
 rtl/mem_access_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store sequencer in front of a small data memory.
// It takes one request at a time, drives the memory write-enable, address and
// write-data lines, and captures load data into a result register. Each
// request ends with a single-cycle done pulse. An unsupported op ends the same
// way, with err pulsed alongside done.
//
// Optional build macro: MEM_CLEAR_EN
//   When it is defined, op=10 zeroes every memory word in turn through the
//   CLR state. When it is undefined, the CLR state and its counter are not
//   built, and op=10 is handled as a reserved op.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   req        request strobe, sampled only in IDLE
//   op         00 load, 01 store, 10 clear (optional), 11 reserved
//   addr       request address
//   wdata      store data
//   busy       high in every state except IDLE
//   done       one-cycle completion pulse
//   err        one-cycle error pulse, coincident with done
//   rdata      load result, held until the next load completes
//   mem_we     memory write enable
//   mem_addr   memory address
//   mem_wdata  memory write data
//   mem_rdata  memory read data (combinational read path)
module mem_access_ctrl #(
    parameter int unsigned size   = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [size-1:0]   wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [size-1:0]   rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [size-1:0]   mem_wdata,
    input  logic [size-1:0]   mem_rdata
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
`ifdef MEM_CLEAR_EN
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
`endif

`ifdef MEM_CLEAR_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        DONE = 3'd3,
        CLR  = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        DONE = 3'd3
    } state_e;
`endif

    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [size-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [size-1:0]   mem_wdata_q, mem_wdata_d;
`ifdef MEM_CLEAR_EN
    logic [ADDR_W-1:0] cnt_q, cnt_d;
`endif

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef MEM_CLEAR_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            we_q        <= we_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef MEM_CLEAR_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Next-state logic. The Moore flags are decoded from state_d, so the
    // flops carry the same values as a decode of state_q, with no glitches.
    always_comb begin
        state_d     = state_q;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef MEM_CLEAR_EN
        cnt_d       = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (req) begin
                    mem_addr_d  = addr;
                    mem_wdata_d = wdata;
                    case (op)
                        OP_LOAD:  state_d = RD;
                        OP_STORE: state_d = WR;
`ifdef MEM_CLEAR_EN
                        OP_CLEAR: begin
                            state_d     = CLR;
                            cnt_d       = '0;
                            mem_addr_d  = '0;
                            mem_wdata_d = '0;
                        end
`endif
                        default: begin
                            state_d = DONE;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            RD: begin
                // Combinational read data is stable for the whole RD cycle
                rdata_d = mem_rdata;
                state_d = DONE;
            end
            WR: state_d = DONE;
`ifdef MEM_CLEAR_EN
            CLR: begin
                // The last word is written in the cycle where cnt_q == CNT_LAST
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d      = cnt_q + ADDR_W'(1);
                    mem_addr_d = cnt_q + ADDR_W'(1);
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
`ifdef MEM_CLEAR_EN
        we_d   = (state_d == WR) || (state_d == CLR);
`else
        we_d   = (state_d == WR);
`endif
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_we    = we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl with an 8-entry memory model. Issued requests push
// their expected completion into a queue. A monitor pops that queue on each
// done pulse and checks it.
module tb_mem_access_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [1:0] op;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic       busy, done, err, mem_we;
    logic [7:0] rdata, mem_wdata, mem_rdata;
    logic [2:0] mem_addr;

    logic [7:0] mem [8];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         at;
        logic       err;
        logic       chk;
        logic [7:0] rd;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   we_addr_q[$];
    int   we_cyc_q[$];

    mem_access_ctrl #(.size(8), .ADDR_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: combinational read, write on the clock edge
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Monitor: log memory writes, and score every done pulse
    always @(negedge clk) begin
        if (mem_we) begin
            we_addr_q.push_back(int'(mem_addr));
            we_cyc_q.push_back(cyc);
        end
        if (err && !done) check("err_without_done", 32'(err), 32'd0);
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_done_cycle"}, 32'(cyc), 32'(e.at));
                check({e.name, "_err"}, 32'(err), 32'(e.err));
                if (e.chk) check({e.name, "_rdata"}, 32'(rdata), 32'(e.rd));
            end
        end
    end

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_idle_timeout"}, 32'(busy), 32'd0);
    endtask

    // Spec cycle E+k is the period after edge E+k-1, so done is seen at cyc E+lat-1
    task automatic issue(input logic [1:0] o, input logic [2:0] a, input logic [7:0] d,
                         input int lat, input logic e_err, input logic chk,
                         input logic [7:0] rd, input string nm, output int e_edge);
        exp_t e;
        req = 1'b1; op = o; addr = a; wdata = d;
        @(posedge clk); #1;
        e_edge = cyc;
        req = 1'b0;
        e.at = e_edge + lat - 1; e.err = e_err; e.chk = chk; e.rd = rd; e.name = nm;
        exp_q.push_back(e);
        wait_idle(nm);
    endtask

    task automatic do_load(input logic [2:0] a, input logic [7:0] v, input string nm);
        int e_edge;
        issue(2'b00, a, 8'h00, 2, 1'b0, 1'b1, v, nm, e_edge);
    endtask

    task automatic do_store(input logic [2:0] a, input logic [7:0] v, input string nm);
        int e_edge;
        issue(2'b01, a, v, 2, 1'b0, 1'b0, 8'h00, nm, e_edge);
    endtask

    initial begin
        int   e_edge;
        int   prev_e;
        logic b;
        exp_t e;

        rst = 1'b1; req = 1'b0; op = 2'b00; addr = 3'd0; wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single store, then a load of the same word
        we_addr_q.delete(); we_cyc_q.delete();
        issue(2'b01, 3'd5, 8'hA7, 2, 1'b0, 1'b0, 8'h00, "st5", e_edge);
        check("st5_we_count", 32'(we_addr_q.size()), 32'd1);
        if (we_addr_q.size() == 1) begin
            check("st5_we_addr", 32'(we_addr_q[0]), 32'd5);
            check("st5_we_cycle", 32'(we_cyc_q[0]), 32'(e_edge));
        end
        do_load(3'd5, 8'hA7, "ld5");

        // Back-to-back stores with req held high
        we_addr_q.delete(); we_cyc_q.delete();
        prev_e = 0;
        req = 1'b1; op = 2'b01;
        for (int i = 0; i < 8; i++) begin
            int n;
            addr = 3'(i); wdata = 8'((i + 1) * 17);
            n = 0;
            do begin
                b = busy;
                @(posedge clk); #1;
                n++;
            end while (b && n < 20);
            check("b2b_accept", 32'(b), 32'd0);
            e.at = cyc + 1; e.err = 1'b0; e.chk = 1'b0; e.rd = 8'h00; e.name = "b2b_st";
            exp_q.push_back(e);
            if (i > 0) check("b2b_gap", 32'(cyc - prev_e), 32'd3);
            prev_e = cyc;
        end
        req = 1'b0;
        wait_idle("b2b");
        check("b2b_we_count", 32'(we_addr_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < we_addr_q.size()) check("b2b_we_addr", 32'(we_addr_q[i]), 32'(i));
        end
        for (int i = 0; i < 8; i++) do_load(3'(i), 8'((i + 1) * 17), "b2b_ld");

        // Requests raised during RD and DONE are dropped
        we_addr_q.delete(); we_cyc_q.delete();
        req = 1'b1; op = 2'b00; addr = 3'd5;
        @(posedge clk); #1;
        e.at = cyc + 1; e.err = 1'b0; e.chk = 1'b1; e.rd = 8'h66; e.name = "ign_rd";
        exp_q.push_back(e);
        op = 2'b01; addr = 3'd2; wdata = 8'h55;
        @(posedge clk); #1;
        check("ign_rd_addr_done", 32'(mem_addr), 32'd5);
        @(posedge clk); #1;
        req = 1'b0;
        check("ign_rd_busy", 32'(busy), 32'd0);
        check("ign_rd_addr", 32'(mem_addr), 32'd5);
        check("ign_rd_rdata", 32'(rdata), 32'h66);
        repeat (3) @(posedge clk);
        #1;
        check("ign_rd_no_write", 32'(we_addr_q.size()), 32'd0);

        // Requests raised during WR and DONE are dropped
        req = 1'b1; op = 2'b01; addr = 3'd1; wdata = 8'h22;
        @(posedge clk); #1;
        e.at = cyc + 1; e.err = 1'b0; e.chk = 1'b0; e.rd = 8'h00; e.name = "ign_wr";
        exp_q.push_back(e);
        op = 2'b00; addr = 3'd6;
        @(posedge clk); #1;
        check("ign_wr_addr_done", 32'(mem_addr), 32'd1);
        @(posedge clk); #1;
        req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("ign_wr_rdata", 32'(rdata), 32'h66);
        check("ign_wr_we_count", 32'(we_addr_q.size()), 32'd1);
        do_load(3'd1, 8'h22, "ign_ld1");
        do_load(3'd2, 8'h33, "ign_ld2");

        // Reserved op
        we_addr_q.delete(); we_cyc_q.delete();
        issue(2'b11, 3'd2, 8'h99, 1, 1'b1, 1'b0, 8'h00, "rsv", e_edge);
        check("rsv_no_write", 32'(we_addr_q.size()), 32'd0);
        do_load(3'd2, 8'h33, "rsv_ld2");

        // Clear after filling every word with 0xFF
        for (int i = 0; i < 8; i++) do_store(3'(i), 8'hFF, "fill");
        we_addr_q.delete(); we_cyc_q.delete();
`ifdef MEM_CLEAR_EN
        issue(2'b10, 3'd4, 8'h12, 9, 1'b0, 1'b0, 8'h00, "clr", e_edge);
        check("clr_we_count", 32'(we_addr_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < we_addr_q.size()) begin
                check("clr_we_addr", 32'(we_addr_q[i]), 32'(i));
                check("clr_we_cycle", 32'(we_cyc_q[i]), 32'(e_edge + i));
            end
        end
        for (int i = 0; i < 8; i++) do_load(3'(i), 8'h00, "clr_ld");

        // Reset during the CLR cycle that writes address 3
        for (int i = 0; i < 8; i++) do_store(3'(i), 8'hFF, "refill");
        req = 1'b1; op = 2'b10; addr = 3'd0;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("clr_rst_addr", 32'(mem_addr), 32'd3);
        check("clr_rst_we", 32'(mem_we), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("clr_rst_busy", 32'(busy), 32'd0);
        check("clr_rst_we_after", 32'(mem_we), 32'd0);
        check("clr_rst_rdata", 32'(rdata), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) do_load(3'(i), (i < 4) ? 8'h00 : 8'hFF, "clr_rst_ld");
`else
        issue(2'b10, 3'd4, 8'h12, 1, 1'b1, 1'b0, 8'h00, "clr_off", e_edge);
        check("clr_off_no_write", 32'(we_addr_q.size()), 32'd0);
        for (int i = 0; i < 8; i++) do_load(3'(i), 8'hFF, "clr_off_ld");
`endif

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
